// File: rtl/finish_banner_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : finish_pkg
// Shared state encoding, screen constants and small elaboration helpers for
// the FINISH banner sequencer.
// Rev 1.0 - initial release
// ============================================================================
package finish_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SLIDE  = 3'd1,
    BOUNCE = 3'd2,
    BLINK  = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } banner_state_t;

  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/finish_banner_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : finish_banner_ctrl_if
// Game-state controls into the banner sequencer and renderer-facing outputs.
// Rev 1.0 - initial release
// ============================================================================
interface finish_banner_ctrl_if;

  logic       frame_tick;
  logic       finish_trig;
  logic       clear;
  logic [9:0] text_x;
  logic [9:0] text_y;
  logic       banner_visible;
  logic       busy;
  logic       done;

  modport master (
    output frame_tick, finish_trig, clear,
    input  text_x, text_y, banner_visible, busy, done
  );

  modport slave (
    input  frame_tick, finish_trig, clear,
    output text_x, text_y, banner_visible, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/finish_banner_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module : frame_timer
// Loadable down-counter advanced by frame_tick; flags the tick seen at zero.
// Rev 1.0 - initial release
// ============================================================================
module frame_timer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_frame_tick,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  output logic                  o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_frame_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A load value of N expires on the (N+1)th frame_tick.
  assign o_expired = i_frame_tick && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/finish_banner_ctrl.sv
`default_nettype none
// ============================================================================
// Module : finish_banner_ctrl
// FINISH banner sequencer: slide-down, blink, hold, latched done; all outputs
// registered and advanced only on frame_tick. Optional overshoot-and-settle
// motion is enabled with `define FINISH_BOUNCE_EN.
// Rev 1.0 - initial release
// ============================================================================
module finish_banner_ctrl
  import finish_pkg::*;
#(
  parameter logic [9:0] TARGET_X      = 10'd300,
  parameter logic [9:0] TARGET_Y      = 10'd236,
  parameter logic [9:0] START_Y       = 10'd0,
  parameter int         SLIDE_STEP    = 4,
  parameter int         BLINK_FRAMES  = 8,
  parameter int         BLINK_TOGGLES = 6,
  parameter int         HOLD_FRAMES   = 120
`ifdef FINISH_BOUNCE_EN
  ,
  parameter int         BOUNCE_PX     = 6
`endif
) (
  input  wire logic           clk,
  input  wire logic           reset,
  finish_banner_ctrl_if.slave bus
);

  localparam int c_TMR_W = $clog2(max_int(max_int(BLINK_FRAMES, HOLD_FRAMES), 2));
  localparam int c_TOG_W = $clog2(BLINK_TOGGLES + 1);

  localparam logic [c_TMR_W-1:0] c_BLINK_LOAD = c_TMR_W'(BLINK_FRAMES - 1);
  localparam logic [c_TMR_W-1:0] c_HOLD_LOAD  = c_TMR_W'(HOLD_FRAMES - 1);
  localparam logic [c_TOG_W-1:0] c_TOG_LAST   = c_TOG_W'(BLINK_TOGGLES - 1);

`ifdef FINISH_BOUNCE_EN
  localparam logic [10:0] c_SLIDE_LIMIT = {1'b0, TARGET_Y} + 11'(BOUNCE_PX);
`else
  localparam logic [10:0] c_SLIDE_LIMIT = {1'b0, TARGET_Y};
`endif

  banner_state_t      r_state, w_state_nxt;
  logic [9:0]         r_text_x;
  logic [9:0]         r_text_y, w_text_y_nxt;
  logic               r_vis, w_vis_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [c_TOG_W-1:0] r_tog_cnt, w_tog_nxt;
  logic [10:0]        w_sum;
  logic               w_tmr_load;
  logic [c_TMR_W-1:0] w_tmr_val;
  logic               w_tmr_expired;
`ifdef FINISH_BOUNCE_EN
  logic [9:0]         w_dec_y;
`endif

  frame_timer #(
    .WIDTH (c_TMR_W)
  ) u_frame_timer (
    .clk          (clk),
    .reset        (reset),
    .i_frame_tick (bus.frame_tick),
    .i_load       (w_tmr_load),
    .i_load_val   (w_tmr_val),
    .o_expired    (w_tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_text_x  <= TARGET_X;
      r_text_y  <= START_Y;
      r_vis     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tog_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_text_x  <= TARGET_X;
      r_text_y  <= w_text_y_nxt;
      r_vis     <= w_vis_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_tog_cnt <= w_tog_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_text_y_nxt = r_text_y;
    w_vis_nxt    = r_vis;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_tog_nxt    = r_tog_cnt;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_sum        = {1'b0, r_text_y} + 11'(SLIDE_STEP);
`ifdef FINISH_BOUNCE_EN
    w_dec_y      = r_text_y - 10'd1;
`endif

    if (bus.clear) begin
      w_state_nxt  = IDLE;
      w_text_y_nxt = START_Y;
      w_vis_nxt    = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_tog_nxt    = '0;
      w_tmr_load   = 1'b1;
    end else if (bus.finish_trig && !r_busy) begin
      // Same-cycle frame_tick is deliberately not consumed here.
      w_state_nxt  = SLIDE;
      w_text_y_nxt = START_Y;
      w_vis_nxt    = 1'b1;
      w_busy_nxt   = 1'b1;
      w_done_nxt   = 1'b0;
      w_tog_nxt    = '0;
      w_tmr_load   = 1'b1;
    end else begin
      case (r_state)
        SLIDE: begin
          if (bus.frame_tick) begin
            if (w_sum >= c_SLIDE_LIMIT) begin
              w_text_y_nxt = c_SLIDE_LIMIT[9:0];
`ifdef FINISH_BOUNCE_EN
              w_state_nxt  = BOUNCE;
`else
              w_state_nxt  = BLINK;
              w_tmr_load   = 1'b1;
              w_tmr_val    = c_BLINK_LOAD;
              w_tog_nxt    = '0;
`endif
            end else begin
              w_text_y_nxt = w_sum[9:0];
            end
          end
        end
`ifdef FINISH_BOUNCE_EN
        BOUNCE: begin
          if (bus.frame_tick) begin
            if ((r_text_y <= TARGET_Y) || (w_dec_y == TARGET_Y)) begin
              w_text_y_nxt = TARGET_Y;
              w_state_nxt  = BLINK;
              w_tmr_load   = 1'b1;
              w_tmr_val    = c_BLINK_LOAD;
              w_tog_nxt    = '0;
            end else begin
              w_text_y_nxt = w_dec_y;
            end
          end
        end
`endif
        BLINK: begin
          if (w_tmr_expired) begin
            w_vis_nxt  = ~r_vis;
            w_tog_nxt  = r_tog_cnt + 1'b1;
            w_tmr_load = 1'b1;
            if (r_tog_cnt == c_TOG_LAST) begin
              w_state_nxt = HOLD;
              w_vis_nxt   = 1'b1;
              w_tmr_val   = c_HOLD_LOAD;
            end else begin
              w_tmr_val   = c_BLINK_LOAD;
            end
          end
        end
        HOLD: begin
          if (w_tmr_expired) begin
            w_state_nxt = DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.text_x         = r_text_x;
  assign bus.text_y         = r_text_y;
  assign bus.banner_visible = r_vis;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;

endmodule
`default_nettype wire

// File: doc/finish_banner_ctrl.md
Name: finish_banner_ctrl

Overview:
Sequences the "FINISH" text renderer when a race ends. On a finish trigger it produces an animated on-screen position and a visibility gate for the renderer. The animation is a slide-down from the top edge, a blink phase, a hold phase, and then a latched done state. The block sits between game-state logic and the VGA overlay mux. All outputs change only on frame boundaries, so the text never tears mid-frame.

Parameters:
TARGET_X, 10'd300, fixed text_x while active
TARGET_Y, 10'd236, final text_y after slide
START_Y, 10'd0, text_y at slide start; must be < TARGET_Y
SLIDE_STEP, 4, pixels per frame during slide; must be ≥1
BLINK_FRAMES, 8, frames per blink half-period
BLINK_TOGGLES, 6, visibility toggles in blink phase (even number, so the phase ends visible)
HOLD_FRAMES, 120, frames in hold phase
BOUNCE_PX, 6, overshoot distance; used only with FINISH_BOUNCE_EN

Ports:
clk  in  1  pixel/system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
finish_trig  in  1  one-cycle pulse: race finished
clear  in  1  one-cycle pulse: abort/dismiss banner, return to idle
text_x  out  10  renderer text_x
text_y  out  10  renderer text_y
banner_visible  out  1  AND-gate for renderer enable
busy  out  1  high in SLIDE/BOUNCE/BLINK/HOLD
done  out  1  high in DONE

Behaviour:
- Reset values:
  - state = IDLE
  - text_x = TARGET_X
  - text_y = START_Y
  - banner_visible = 0, busy = 0, done = 0
  - frame counter = 0, toggle counter = 0
- All outputs are registered.
- States: IDLE, SLIDE, BOUNCE (only with FINISH_BOUNCE_EN), BLINK, HOLD, DONE.
- IDLE:
  - Outputs are at reset values.
  - finish_trig → SLIDE on the next clk. text_y = START_Y, banner_visible = 1, busy = 1, both set in that same edge.
- SLIDE: on each frame_tick, text_y += SLIDE_STEP, computed 11-bit.
  - If the sum ≥ TARGET_Y: text_y = TARGET_Y (clamp) and go to BLINK.
  - With FINISH_BOUNCE_EN, the clamp limit is TARGET_Y+BOUNCE_PX and the next state is BOUNCE instead.
- BLINK: frame counter counts frame_ticks.
  - When it reaches BLINK_FRAMES-1, banner_visible toggles, the counter resets to 0, and the toggle counter increments.
  - After BLINK_TOGGLES toggles → HOLD, with banner_visible = 1.
- HOLD: after HOLD_FRAMES frame_ticks → DONE (busy = 0, done = 1, banner_visible stays 1).
- DONE: holds indefinitely. A new finish_trig restarts SLIDE, same as from IDLE.
- clear: in any state → IDLE on the next clk, with all outputs at reset values.
- Priority:
  - clear beats finish_trig in the same cycle.
  - finish_trig is ignored while busy = 1.
  - A frame_tick in the same cycle as finish_trig does not advance the slide; the first step happens on the next frame_tick.
- No timing is counted without frame_tick. Latency from a trigger to the first text_y movement is one frame.
- Asynchronous reset mid-animation returns to the reset values immediately.

Optional Feature:
FINISH_BOUNCE_EN:
- Defined:
  - SLIDE overshoots to TARGET_Y+BOUNCE_PX, clamped, as described above.
  - BOUNCE then decrements text_y by 1 per frame_tick until it equals TARGET_Y, then goes to BLINK.
- Undefined: the BOUNCE state and the BOUNCE_PX logic are absent, and SLIDE goes directly to BLINK at TARGET_Y.

Decomposition:
- Shared package finish_pkg holds:
  - typedef enum logic [2:0] banner_state_t {IDLE, SLIDE, BOUNCE, BLINK, HOLD, DONE}
  - default screen constants: SCREEN_H=480, SCREEN_W=640
- One sub-module, frame_timer. It is a loadable down-counter clocked by frame_tick. It takes a load value and load strobe, decrements on each frame_tick, and outputs an expired pulse. It is reused for the BLINK and HOLD phase timing.

Test Plan:
- Trig with defaults, no macro: text_y steps 0,4,8,…,232, then clamps to 236 on the 59th frame_tick; the state then enters BLINK.
- Blink: after the slide, banner_visible toggles every 8 frames, 6 times. It is 1 at the HOLD entry, done = 1 exactly 120 frames later, and busy falls in that same cycle.
- clear pulsed during BLINK while banner_visible = 0: the next cycle gives IDLE, banner_visible = 0, text_y = 0, busy = 0.
- finish_trig and clear in the same cycle from IDLE: the block stays in IDLE. A second finish_trig during SLIDE does not reset text_y.
- With FINISH_BOUNCE_EN defined: text_y reaches 242, then steps 241…236 one per frame, then enters BLINK.
- Reset asserted mid-HOLD, asynchronously between clock edges: outputs go to reset values without waiting for a clock edge.
